// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the program counter, reads the instruction ROM combinationally
// and presents each word to decode through a single-entry valid/ready output stage.
module instruction_fetch_unit #(
   parameter int unsigned INSTRUCTION_WIDTH                = 32,
   parameter int unsigned INSTRUCTION_MEMORY_ADDRESS_WIDTH = 16,
   parameter logic [INSTRUCTION_MEMORY_ADDRESS_WIDTH-1:0] RESET_ADDRESS = '0,
   parameter logic [INSTRUCTION_WIDTH-1:0] HALT_INSTRUCTION = 32'h0010_0073
) (
   input  logic                                        clock,
   input  logic                                        reset_n,
   input  logic                                        fetch_enable,
   output logic [INSTRUCTION_MEMORY_ADDRESS_WIDTH-1:0] instruction_address,
   input  logic [INSTRUCTION_WIDTH-1:0]                instruction_data,
   input  logic                                        redirect_valid,
   input  logic [INSTRUCTION_MEMORY_ADDRESS_WIDTH-1:0] redirect_address,
   output logic                                        fetch_valid,
   input  logic                                        fetch_ready,
   output logic [INSTRUCTION_WIDTH-1:0]                fetch_instruction,
   output logic [INSTRUCTION_MEMORY_ADDRESS_WIDTH-1:0] fetch_address,
   output logic                                        halted,
   output logic [31:0]                                 fetched_count
);

   localparam int unsigned AW = INSTRUCTION_MEMORY_ADDRESS_WIDTH;
   localparam logic [AW-1:0] PC_STEP = 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUNNING = 2'd1,
      HALTED  = 2'd2
   } state_t;

   state_t        state;
   state_t        state_next;
   logic [AW-1:0] pc;
   logic          slot_free;
   logic          handshake;
   logic          capture;
   logic          capture_is_halt;

   assign instruction_address = pc;
   assign slot_free           = !fetch_valid || fetch_ready;
   assign handshake           = fetch_valid && fetch_ready;
   // Redirect outranks capture: the word on the ROM bus belongs to the old path.
   assign capture             = (state == RUNNING) && slot_free && !redirect_valid;
   assign capture_is_halt     = capture && (instruction_data == HALT_INSTRUCTION);
   assign halted              = (state == HALTED);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // NOTE: next state is defaulted first so no path through the case leaves it unassigned (no latch).
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (!redirect_valid && fetch_enable) begin
               state_next = RUNNING;
            end
         end
         RUNNING: begin
            if (capture_is_halt) begin
               state_next = HALTED;
            end
         end
         HALTED: begin
            if (redirect_valid) begin
               state_next = RUNNING;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pc                <= RESET_ADDRESS;
         fetch_valid       <= 1'b0;
         fetch_instruction <= '0;
         fetch_address     <= '0;
      end else if (redirect_valid) begin
         pc          <= redirect_address;
         fetch_valid <= 1'b0;
      end else if (capture) begin
         fetch_instruction <= instruction_data;
         fetch_address     <= pc;
         fetch_valid       <= 1'b1;
         pc                <= pc + PC_STEP;
      end else if (handshake) begin
         fetch_valid <= 1'b0;
      end
   end

   // A handshake on the same edge as a redirect still counts as delivered.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         fetched_count <= '0;
      end else if (handshake) begin
         fetched_count <= fetched_count + 32'd1;
      end
   end

endmodule
